// File: rtl/zero_skip_dot_unit_if.sv
// Stream bundle for zero_skip_dot_unit: operand beats in, dot-product results out.
// master = upstream/downstream side (testbench or datapath), slave = the dot unit.
interface zero_skip_dot_unit_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_a;
    logic [LANES*DATA_W-1:0]   in_b;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [ACC_W-1:0]          out_acc;
    logic [LANES-1:0]          out_skip_mask;
    logic [15:0]               out_skip_cnt;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_skip_mask, out_skip_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_skip_mask, out_skip_cnt
    );
endinterface

// File: rtl/zero_skip_dot_unit.sv
// Multi-lane zero-skipping dot-product unit: S1 multiplies lanes, S2 sums and accumulates.
// Optional per-vector skip counter enabled by defining ZERO_SKIP_STATS_EN.
module zero_skip_dot_unit #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    zero_skip_dot_unit_if.slave   bus
);
    localparam int PROD_W = 2 * DATA_W;

    logic                w_adv;
    logic [LANES-1:0]    w_skip;
    logic [PROD_W-1:0]   w_prod [LANES];
    logic [ACC_W-1:0]    w_ext  [LANES];
    logic [ACC_W-1:0]    w_sum;

    logic                r_s1_valid;
    logic                r_s1_last;
    logic [LANES-1:0]    r_s1_mask;
    logic [PROD_W-1:0]   r_s1_prod [LANES];
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_out_acc;
    logic [LANES-1:0]    r_out_mask;
    logic                r_out_valid;

    // The whole pipeline freezes only while a result sits unaccepted.
    assign w_adv        = !(r_out_valid && !bus.out_ready);
    assign bus.in_ready = w_adv;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_W-1:0] w_a;
        logic [DATA_W-1:0] w_b;
        assign w_a        = bus.in_a[gi*DATA_W +: DATA_W];
        assign w_b        = bus.in_b[gi*DATA_W +: DATA_W];
        assign w_skip[gi] = (w_a == '0) || (w_b == '0);
        if (SIGNED != 0) begin : g_signed
            logic signed [PROD_W-1:0] w_mul;
            assign w_mul      = $signed(w_a) * $signed(w_b);
            assign w_prod[gi] = w_skip[gi] ? '0 : w_mul;
            assign w_ext[gi]  = ACC_W'($signed(r_s1_prod[gi]));
        end else begin : g_unsigned
            assign w_prod[gi] = w_skip[gi] ? '0 : PROD_W'(w_a) * PROD_W'(w_b);
            assign w_ext[gi]  = ACC_W'(r_s1_prod[gi]);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + w_ext[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_mask   <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_prod[i] <= '0;
            end
            r_acc       <= '0;
            r_out_acc   <= '0;
            r_out_mask  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= bus.in_valid;
            r_s1_last  <= bus.in_last;
            r_s1_mask  <= w_skip;
            for (int i = 0; i < LANES; i++) begin
                r_s1_prod[i] <= w_prod[i];
            end
            // When advancing with a result held, out_ready is high, so that result is popped.
            if (r_s1_valid && r_s1_last) begin
                r_out_acc   <= r_acc + w_sum;
                r_out_mask  <= r_s1_mask;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
            end else begin
                if (r_s1_valid) begin
                    r_acc <= r_acc + w_sum;
                end
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.out_acc       = r_out_acc;
    assign bus.out_skip_mask = r_out_mask;

`ifdef ZERO_SKIP_STATS_EN
    logic [15:0] r_cnt;
    logic [15:0] r_out_cnt;
    logic [15:0] w_pop;
    logic [16:0] w_cnt_sum;
    logic [15:0] w_cnt_next;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + 16'(r_s1_mask[i]);
        end
    end

    // Saturate rather than wrap so a huge sparse vector still reads as "very many".
    assign w_cnt_sum  = {1'b0, r_cnt} + {1'b0, w_pop};
    assign w_cnt_next = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_out_cnt <= '0;
        end else if (w_adv && r_s1_valid) begin
            if (r_s1_last) begin
                r_out_cnt <= w_cnt_next;
                r_cnt     <= '0;
            end else begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    assign bus.out_skip_cnt = r_out_cnt;
`else
    assign bus.out_skip_cnt = '0;
`endif
endmodule

// File: tb/tb_zero_skip_dot_unit.sv
// Directed bench for zero_skip_dot_unit: unsigned and signed instances fed the same stream.
// Skip-count expectations follow ZERO_SKIP_STATS_EN.
module tb_zero_skip_dot_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    zero_skip_dot_unit_if #(.LANES(4), .DATA_W(8), .ACC_W(32)) bu ();
    zero_skip_dot_unit_if #(.LANES(4), .DATA_W(8), .ACC_W(32)) bs ();

    assign bs.in_valid  = bu.in_valid;
    assign bs.in_a      = bu.in_a;
    assign bs.in_b      = bu.in_b;
    assign bs.in_last   = bu.in_last;
    assign bs.out_ready = bu.out_ready;

    zero_skip_dot_unit #(.LANES(4), .DATA_W(8), .ACC_W(32), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .bus(bu.slave));
    zero_skip_dot_unit #(.LANES(4), .DATA_W(8), .ACC_W(32), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bs.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] acc;
        logic [3:0]  mask;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [4];

    function automatic logic [31:0] p4(input logic [7:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [15:0] ecnt(input logic [15:0] c);
`ifdef ZERO_SKIP_STATS_EN
        return c;
`else
        return (c & 16'h0000);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        int n;
        bu.in_a = a; bu.in_b = b; bu.in_last = last; bu.in_valid = 1'b1;
        n = 0;
        while (!bu.in_ready && n < 50) begin
            step();
            n++;
        end
        if (!bu.in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready=%0b expected 1", bu.in_ready);
        end
        step();
        bu.in_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!bu.out_valid && n < 20) begin
            step();
            n++;
        end
        if (!bu.out_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL result_timeout: out_valid=%0b expected 1", bu.out_valid);
        end
    endtask

    task automatic chk_u(input string name, input logic [31:0] acc, input logic [3:0] mask, input logic [15:0] cnt);
        chk({name, "_acc"},  bu.out_acc, acc);
        chk({name, "_mask"}, 32'(bu.out_skip_mask), 32'(mask));
        chk({name, "_cnt"},  32'(bu.out_skip_cnt), 32'(ecnt(cnt)));
    endtask

    task automatic chk_s(input string name, input logic [31:0] acc, input logic [3:0] mask, input logic [15:0] cnt);
        chk({name, "_acc"},  bs.out_acc, acc);
        chk({name, "_mask"}, 32'(bs.out_skip_mask), 32'(mask));
        chk({name, "_cnt"},  32'(bs.out_skip_cnt), 32'(ecnt(cnt)));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        tbl[0] = '{p4(0, 0, 0, 0),         p4(1, 2, 3, 4),         32'd0,      4'b1111, 16'd4};
        tbl[1] = '{p4(255, 255, 255, 255), p4(255, 255, 255, 255), 32'd260100, 4'b0000, 16'd0};
        tbl[2] = '{p4(1, 0, 3, 0),         p4(0, 5, 7, 9),         32'd21,     4'b1011, 16'd3};
        tbl[3] = '{p4(10, 20, 30, 40),     p4(2, 0, 1, 3),         32'd170,    4'b0010, 16'd1};

        rst_n = 1'b0;
        bu.in_valid = 1'b0; bu.in_a = '0; bu.in_b = '0; bu.in_last = 1'b0; bu.out_ready = 1'b1;
        #22 rst_n = 1'b1;
        step();
        chk("reset_valid", 32'(bu.out_valid), 32'd0);
        chk("reset_ready", 32'(bu.in_ready), 32'd1);
        chk_u("reset", 32'd0, 4'b0000, 16'd0);

        // Latency: captured at one edge, result visible after the next.
        send(p4(1, 2, 3, 4), p4(5, 6, 7, 8), 1'b1);
        chk("lat_valid_early", 32'(bu.out_valid), 32'd0);
        step();
        chk("lat_valid", 32'(bu.out_valid), 32'd1);
        chk_u("lat", 32'd70, 4'b0000, 16'd0);
        step();
        chk("lat_popped", 32'(bu.out_valid), 32'd0);

        // Two-beat vector with skipped lanes in the first beat.
        send(p4(0, 2, 0, 4), p4(9, 3, 9, 1), 1'b0);
        send(p4(1, 1, 1, 1), p4(1, 1, 1, 1), 1'b1);
        wait_res();
        chk_u("two_beat", 32'd14, 4'b0000, 16'd2);
        step();

        for (int i = 0; i < 4; i++) begin
            send(tbl[i].a, tbl[i].b, 1'b1);
            wait_res();
            chk_u($sformatf("tbl%0d", i), tbl[i].acc, tbl[i].mask, tbl[i].cnt);
            step();
        end

        // Backpressure: result held, next beat blocked, then released.
        bu.out_ready = 1'b0;
        send(p4(1, 1, 1, 1), p4(2, 2, 2, 2), 1'b1);
        wait_res();
        bu.in_a = p4(3, 0, 0, 0); bu.in_b = p4(3, 0, 0, 0); bu.in_last = 1'b1; bu.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_ready", k), 32'(bu.in_ready), 32'd0);
            chk($sformatf("stall%0d_acc", k), bu.out_acc, 32'd8);
            step();
        end
        bu.out_ready = 1'b1;
        step();
        bu.in_valid = 1'b0;
        chk("stall_pop_valid", 32'(bu.out_valid), 32'd0);
        step();
        chk("stall_next_valid", 32'(bu.out_valid), 32'd1);
        chk_u("stall_next", 32'd9, 4'b1110, 16'd3);
        step();
        chk("stall_no_dup", 32'(bu.out_valid), 32'd0);

        // Back-to-back single-beat vectors: result k is 2k+5.
        for (int k = 0; k < 7; k++) begin
            if (k >= 2 && k < 6) begin
                chk($sformatf("b2b%0d_valid", k - 2), 32'(bu.out_valid), 32'd1);
                chk($sformatf("b2b%0d_acc", k - 2), bu.out_acc, 32'(2 * (k - 2) + 5));
            end
            if (k == 6) chk("b2b_drain_valid", 32'(bu.out_valid), 32'd0);
            if (k < 4) begin
                bu.in_a = p4(8'(k + 1), 1, 0, 0); bu.in_b = p4(2, 3, 0, 0);
                bu.in_last = 1'b1; bu.in_valid = 1'b1;
            end else begin
                bu.in_valid = 1'b0;
            end
            step();
        end

        // Signed instance; unsigned instance sees the same bytes as unsigned values.
        send(p4(8'hFD, 8'h02, 8'h00, 8'hFF), p4(8'h04, 8'hFB, 8'h07, 8'hFE), 1'b1);
        wait_res();
        chk_s("signed1", 32'hFFFF_FFEC, 4'b0100, 16'd1);
        step();
        send(p4(8'h80, 0, 0, 0), p4(8'h80, 0, 0, 0), 1'b0);
        send(p4(8'hFF, 0, 0, 0), p4(8'h01, 0, 0, 0), 1'b1);
        wait_res();
        chk_s("signed2", 32'd16383, 4'b1110, 16'd6);
        chk_u("unsigned2", 32'd16639, 4'b1110, 16'd6);
        step();

        // Asynchronous reset mid-vector, between clock edges.
        send(p4(5, 5, 5, 5), p4(5, 5, 5, 5), 1'b0);
        bu.in_a = p4(6, 6, 6, 6); bu.in_b = p4(6, 6, 6, 6); bu.in_last = 1'b0; bu.in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bu.out_valid), 32'd0);
        chk_u("arst", 32'd0, 4'b0000, 16'd0);
        chk("arst_s_acc", bs.out_acc, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        bu.in_valid = 1'b0;
        step();
        chk("arst_idle_valid", 32'(bu.out_valid), 32'd0);
        send(p4(1, 0, 0, 0), p4(1, 0, 0, 0), 1'b0);
        send(p4(0, 2, 0, 0), p4(0, 3, 0, 0), 1'b0);
        send(p4(0, 0, 0, 4), p4(0, 0, 0, 5), 1'b1);
        wait_res();
        chk_u("post_rst", 32'd27, 4'b0111, 16'd9);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
